// File: rtl/srjk_pkg.sv
// Shared definitions for the SR/JK flip-flop demo sequencer.
// - state_t   : controller states; the encoding is what drives state_led.
// - SR_*      : {S,R} input codes for the flip-flop.
// - PATTERN   : the fixed 8-step {S,R} sequence used in automatic mode.
package srjk_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    PAUSE  = 2'b10
  } state_t;

  typedef logic [1:0] sr_code_t;

  localparam sr_code_t SR_HOLD  = 2'b00;
  localparam sr_code_t SR_RESET = 2'b01;
  localparam sr_code_t SR_SET   = 2'b10;
  localparam sr_code_t SR_BOTH  = 2'b11;

  // Walks set, hold, reset, hold, then two "both" steps (toggle in JK mode,
  // invalid in SR mode), a hold, and a final set that recovers a valid Q.
  localparam sr_code_t PATTERN [0:7] = '{
    SR_SET, SR_HOLD, SR_RESET, SR_HOLD, SR_BOTH, SR_BOTH, SR_HOLD, SR_SET
  };

endpackage

// File: rtl/srjk_demo_sequencer_if.sv
// Board-side signal bundle of the demo sequencer.
// master : the sequencer (reads switches/button, drives flip-flop controls
//          and status LEDs).
// slave  : the board / environment side.
// Signals:
//   run_sw, jk_mode, sw_s, sw_r, step_btn    board inputs
//   s_out, r_out, ff_tick                    flip-flop controls
//   q_model, q_valid                         golden Q and its validity
//   pat_idx, state_led, clk_disp             status outputs
interface srjk_demo_sequencer_if;

  logic       run_sw;
  logic       jk_mode;
  logic       sw_s;
  logic       sw_r;
  logic       step_btn;
  logic       s_out;
  logic       r_out;
  logic       ff_tick;
  logic       q_model;
  logic       q_valid;
  logic [2:0] pat_idx;
  logic [1:0] state_led;
  logic       clk_disp;

  modport master (
    input  run_sw, jk_mode, sw_s, sw_r, step_btn,
    output s_out, r_out, ff_tick, q_model, q_valid, pat_idx, state_led, clk_disp
  );

  modport slave (
    output run_sw, jk_mode, sw_s, sw_r, step_btn,
    input  s_out, r_out, ff_tick, q_model, q_valid, pat_idx, state_led, clk_disp
  );

endinterface

// File: rtl/btn_debounce.sv
// Debouncer for an already synchronised button level.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   din      : synchronised raw button level
//   level    : debounced level; follows din only after DEBOUNCE_CYCLES
//              consecutive samples that differ from the current level
//   rise     : one-cycle pulse, asserted together with a 0->1 change of level
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          rise_reg;

  // cnt_reg counts differing samples already seen; the sample that would
  // make it DEBOUNCE_CYCLES flips the level instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      if (din == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= din;
        rise_reg  <= din;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/srjk_demo_sequencer.sv
// Controller for the board's SR/JK flip-flop demo.
// Drives S/R and a one-cycle sample enable (ff_tick) for the flip-flop, either
// from the slide switches plus a debounced step button (MANUAL) or from a
// fixed 8-step pattern paced by a free-running divider (AUTO, PAUSE). Keeps a
// golden copy of the expected Q for checking and LEDs.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : master modport of srjk_demo_sequencer_if (switch/button inputs,
//              flip-flop controls, golden Q, status LEDs)
module srjk_demo_sequencer
  import srjk_pkg::*;
#(
  parameter int DIV_COUNT       = 70_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  srjk_demo_sequencer_if.master bus
);

  localparam int DIV_W = $clog2(DIV_COUNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

  // ---------------- divider (free running in every state) ----------------
  logic [DIV_W-1:0] cnt_reg;
  logic             clk_disp_reg;
  logic             div_tick;

  assign div_tick = (cnt_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      clk_disp_reg <= 1'b0;
    end else if (div_tick) begin
      cnt_reg      <= '0;
      clk_disp_reg <= ~clk_disp_reg;
    end else begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end

  // ---------------- step button: synchroniser + debouncer ----------------
  logic [1:0] sync_reg;
  logic       btn_level;
  logic       btn_rise;
  logic       step_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], bus.step_btn};
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (sync_reg[1]),
    .level(btn_level),
    .rise (btn_rise)
  );

  // rise is only ever asserted with level already high; the AND keeps the
  // qualifier explicit.
  assign step_pulse = btn_rise & btn_level;

  // ---------------- FSM, pattern pointer, golden model ----------------
  state_t   state_reg, state_next;
  logic [2:0] pat_reg, pat_next;
  sr_code_t sr_reg, sr_next;
  logic     ff_tick_reg, ff_tick_next;
  logic     q_reg, q_next;
  logic     qv_reg, qv_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= MANUAL;
      pat_reg     <= 3'd0;
      sr_reg      <= SR_HOLD;
      ff_tick_reg <= 1'b0;
      q_reg       <= 1'b0;
      qv_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      pat_reg     <= pat_next;
      sr_reg      <= sr_next;
      ff_tick_reg <= ff_tick_next;
      q_reg       <= q_next;
      qv_reg      <= qv_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pat_next     = pat_reg;
    ff_tick_next = 1'b0;
    q_next       = q_reg;
    qv_next      = qv_reg;
    sr_next      = sr_reg;

    // Golden flip-flop: evaluated with the S/R actually presented during the
    // tick cycle. In SR mode Q keeps its stale value while marked invalid.
    if (ff_tick_reg) begin
      case (sr_reg)
        SR_RESET: begin q_next = 1'b0; qv_next = 1'b1; end
        SR_SET:   begin q_next = 1'b1; qv_next = 1'b1; end
        SR_BOTH: begin
          if (bus.jk_mode) q_next  = ~q_reg;
          else             qv_next = 1'b0;
        end
        default: ;
      endcase
    end

    // An automatic tick moves the pattern on in the cycle after it was
    // issued, even if a state change happens in that same cycle.
    if (state_reg == AUTO && ff_tick_reg) pat_next = pat_reg + 3'd1;

    // A state change suppresses any tick in the same cycle.
    case (state_reg)
      MANUAL: begin
        if (bus.run_sw) begin
          state_next = AUTO;
          pat_next   = 3'd0;
        end else begin
          ff_tick_next = step_pulse;
        end
      end
      AUTO: begin
        if (!bus.run_sw)     state_next = MANUAL;
        else if (step_pulse) state_next = PAUSE;
        else                 ff_tick_next = div_tick;
      end
      PAUSE: begin
        if (!bus.run_sw)     state_next = MANUAL;
        else if (step_pulse) state_next = AUTO;
      end
      default: state_next = MANUAL;
    endcase

    // MANUAL mirrors the switches; AUTO/PAUSE present the pattern entry at
    // the (possibly just advanced) index. PAUSE never moves the index, so
    // its outputs hold.
    if (state_next == MANUAL) sr_next = {bus.sw_s, bus.sw_r};
    else                      sr_next = PATTERN[pat_next];
  end

  assign bus.s_out     = sr_reg[1];
  assign bus.r_out     = sr_reg[0];
  assign bus.ff_tick   = ff_tick_reg;
  assign bus.q_model   = q_reg;
  assign bus.q_valid   = qv_reg;
  assign bus.pat_idx   = pat_reg;
  assign bus.state_led = state_reg;
  assign bus.clk_disp  = clk_disp_reg;

endmodule

// File: tb/tb_srjk_demo_sequencer.sv
// Self-checking bench for srjk_demo_sequencer (DIV_COUNT=4, DEBOUNCE_CYCLES=3).
// A behavioural model runs alongside the DUT and is compared on every cycle;
// directed scenarios add literal expectations; a randomized phase follows.
module tb_srjk_demo_sequencer;

  localparam int DIV  = 4;
  localparam int DEB  = 3;
  localparam int HLEN = DEB + 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  srjk_demo_sequencer_if bus ();

  srjk_demo_sequencer #(
    .DIV_COUNT      (DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned cyc;        // clocks since reset
  int          m_mode;     // 0 manual, 1 auto, 2 pause (matches LED code)
  int          m_idx;
  bit          m_s, m_r, m_tick, m_q, m_qv, m_clk;
  bit          m_level, m_pulse;
  bit          raw_hist [HLEN];  // raw_hist[k] = button sampled k+1 clocks ago
  bit          m_started;
  bit [1:0]    pat_tbl [8];

  task automatic model_step();
    bit div, nq, nqv, ntick, same;
    int nmode, nidx;
    if (rst) begin
      cyc = 0; m_mode = 0; m_idx = 0;
      m_s = 0; m_r = 0; m_tick = 0; m_q = 0; m_qv = 1; m_clk = 0;
      m_level = 0; m_pulse = 0;
      for (int k = 0; k < HLEN; k++) raw_hist[k] = 1'b0;
      m_started = 1'b1;
      return;
    end
    div = ((cyc % DIV) == DIV - 1);
    // flip-flop truth table on a tick
    nq = m_q; nqv = m_qv;
    if (m_tick) begin
      if (m_s && !m_r)      begin nq = 1; nqv = 1; end
      else if (!m_s && m_r) begin nq = 0; nqv = 1; end
      else if (m_s && m_r)  begin
        if (bus.jk_mode) nq = !m_q;
        else             nqv = 0;
      end
    end
    // mode rules
    nmode = m_mode; nidx = m_idx; ntick = 0;
    if (m_mode == 1 && m_tick) nidx = (m_idx + 1) % 8;
    if (m_mode == 0) begin
      if (bus.run_sw) begin nmode = 1; nidx = 0; end
      else ntick = m_pulse;
    end else if (!bus.run_sw) begin
      nmode = 0;
    end else if (m_pulse) begin
      nmode = (m_mode == 1) ? 2 : 1;
    end else if (m_mode == 1) begin
      ntick = div;
    end
    // debounced level: flips once the last DEB synchronised samples
    // (which lag the raw pin by two clocks) all disagree with it
    same = 1;
    for (int k = 1; k <= DEB; k++) if (raw_hist[k] == m_level) same = 0;
    m_pulse = 0;
    if (same) begin
      m_level = !m_level;
      m_pulse = m_level;
    end
    for (int k = HLEN - 1; k > 0; k--) raw_hist[k] = raw_hist[k-1];
    raw_hist[0] = bus.step_btn;
    // commit
    if (nmode == 0) begin m_s = bus.sw_s; m_r = bus.sw_r; end
    else            {m_s, m_r} = pat_tbl[nidx];
    m_mode = nmode; m_idx = nidx; m_tick = ntick;
    m_q = nq; m_qv = nqv;
    if (div) m_clk = !m_clk;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    if (!m_started) return;
    chk("s_out",     32'(bus.s_out),     32'(m_s));
    chk("r_out",     32'(bus.r_out),     32'(m_r));
    chk("ff_tick",   32'(bus.ff_tick),   32'(m_tick));
    chk("q_model",   32'(bus.q_model),   32'(m_q));
    chk("q_valid",   32'(bus.q_valid),   32'(m_qv));
    chk("pat_idx",   32'(bus.pat_idx),   32'(m_idx));
    chk("state_led", 32'(bus.state_led), 32'(m_mode));
    chk("clk_disp",  32'(bus.clk_disp),  32'(m_clk));
  endtask

  // one clock: model follows the edge, DUT is compared mid-cycle
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp_sr [8];
  int exp_q  [8];
  int exp_qv [8];
  int sr_seen [8];
  int q_seen  [8];
  int qv_seen [8];
  int got, lat, nt, frozen, hold;
  bit found;

  initial begin
    checks = 0; errors = 0; m_started = 0;
    pat_tbl = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10};
    exp_sr  = '{2, 0, 1, 0, 3, 3, 0, 2};
    exp_q   = '{1, 1, 0, 0, 1, 0, 0, 1};
    exp_qv  = '{1, 1, 1, 1, 0, 0, 0, 1};
    rst = 1'b1;
    bus.run_sw = 0; bus.jk_mode = 0; bus.sw_s = 0; bus.sw_r = 0; bus.step_btn = 0;

    // ---- reset state ----
    do_reset();
    chk("rst_qv", 32'(bus.q_valid), 1);
    chk("rst_state", 32'(bus.state_led), 0);

    // ---- 1: automatic pattern, JK ----
    do_reset();
    bus.run_sw = 1; bus.jk_mode = 1;
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      tick();
      if (bus.ff_tick) begin
        sr_seen[got] = {bus.s_out, bus.r_out};
        tick();
        q_seen[got] = bus.q_model;
        got++;
      end
    end
    chk("s1_ticks", 32'(got), 8);
    for (int i = 0; i < 8; i++) begin
      chk("s1_sr", 32'(sr_seen[i]), 32'(exp_sr[i]));
      chk("s1_q",  32'(q_seen[i]),  32'(exp_q[i]));
    end
    chk("s1_wrap", 32'(bus.pat_idx), 0);

    // ---- 2: automatic pattern, SR ----
    do_reset();
    bus.run_sw = 1; bus.jk_mode = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      tick();
      if (bus.ff_tick) begin
        tick();
        qv_seen[got] = bus.q_valid;
        q_seen[got]  = bus.q_model;
        got++;
      end
    end
    chk("s2_ticks", 32'(got), 8);
    for (int i = 0; i < 8; i++) chk("s2_qv", 32'(qv_seen[i]), 32'(exp_qv[i]));
    chk("s2_q7", 32'(q_seen[7]), 1);

    // ---- 3: manual step, latency and glitch rejection ----
    do_reset();
    bus.run_sw = 0; bus.jk_mode = 0; bus.sw_s = 1; bus.sw_r = 0;
    tick(); tick(); tick();
    bus.step_btn = 1; lat = 0; nt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.ff_tick) begin nt++; if (lat == 0) lat = k; end
    end
    bus.step_btn = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (bus.ff_tick) nt++; end
    chk("s3_latency", 32'(lat), 6);
    chk("s3_count", 32'(nt), 1);
    chk("s3_q", 32'(bus.q_model), 1);
    bus.step_btn = 1; tick(); tick(); bus.step_btn = 0;
    nt = 0;
    for (int k = 0; k < 15; k++) begin tick(); if (bus.ff_tick) nt++; end
    chk("s3_glitch", 32'(nt), 0);

    // ---- 4: pause and resume ----
    do_reset();
    bus.run_sw = 1; bus.jk_mode = 1;
    for (int k = 0; k < 10; k++) tick();
    bus.step_btn = 1; found = 0;
    for (int k = 0; k < 12 && !found; k++) begin tick(); found = (bus.state_led == 2'b10); end
    chk("s4_paused", 32'(found), 1);
    frozen = bus.pat_idx;
    bus.step_btn = 0; nt = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (bus.ff_tick) nt++; end
    chk("s4_noticks", 32'(nt), 0);
    chk("s4_frozen", 32'(bus.pat_idx), 32'(frozen));
    bus.step_btn = 1; found = 0;
    for (int k = 0; k < 12 && !found; k++) begin tick(); found = (bus.state_led == 2'b01); end
    chk("s4_resumed", 32'(found), 1);
    chk("s4_idx", 32'(bus.pat_idx), 32'(frozen));
    bus.step_btn = 0;
    for (int k = 0; k < 6; k++) tick();

    // ---- 5: leave AUTO on a divider tick ----
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin tick(); found = bus.ff_tick; end
    chk("s5_sync", 32'(found), 1);
    tick(); tick(); tick();
    bus.run_sw = 0;
    tick();
    chk("s5_state", 32'(bus.state_led), 0);
    chk("s5_notick", 32'(bus.ff_tick), 0);
    bus.run_sw = 1;
    tick();
    chk("s5_auto", 32'(bus.state_led), 1);
    chk("s5_idx0", 32'(bus.pat_idx), 0);

    // ---- 6: reset mid-pattern ----
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin tick(); found = bus.q_model; end
    chk("s6_q1", 32'(found), 1);
    rst = 1'b1;
    tick();
    chk("s6_outs", 32'({bus.s_out, bus.r_out, bus.ff_tick, bus.q_model, bus.q_valid,
                        bus.pat_idx, bus.state_led, bus.clk_disp}), 32'(11'b00001_000_00_0));
    rst = 1'b0;

    // ---- randomized phase ----
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) bus.run_sw = !bus.run_sw;
      if ($urandom_range(0, 99) == 0) bus.jk_mode = !bus.jk_mode;
      if ($urandom_range(0, 7) == 0) begin
        bus.sw_s = 1'($urandom);
        bus.sw_r = 1'($urandom);
      end
      if (hold == 0) begin
        bus.step_btn = 1'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
